mult_share_ctrl: RTL and testbench
==================================

# mult_share_ctrl

Two-port arbiter and sequencer for the shared 32x32 multiplier datapath (signed and unsigned). Accepts multiply requests from two requesters, round-robin arbitrates, drives the multiplier operands and signedness select, holds them for a programmable settle window covering the deep ripple-adder chain, then captures the 64-bit product and returns it with a one-cycle completion pulse tagged by requester. Sits between the ALU/datapath issue logic and the combinational multiplier, which is instantiated outside this block.

## Interface
- SETTLE_CYCLES, 3, clock cycles operands are held stable before the product is captured; legal range 1..15.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- REQ0 / REQ1  in  1  request from port 0 / port 1, level.
- SGN0 / SGN1  in  1  1 = signed multiply, 0 = unsigned, for that port.
- A0, B0 / A1, B1  in  32  operands for that port; valid while REQx high.
- GNT0 / GNT1  out  1  one-cycle pulse: port's operands were accepted.
- MA, MB  out  32  operand registers driven to the multiplier.
- MSGN  out  1  signed/unsigned result select to the multiplier.
- MHI, MLO  in  32  multiplier product high/low.
- HI, LO  out  32  captured product, held until the next capture.
- DONE  out  1  one-cycle pulse: HI/LO hold a new result.
- DONE_ID  out  1  port that owns the current HI/LO.
- BUSY  out  1  high while an operation is in flight (state != IDLE).

## Operation
- States: IDLE, WAIT.
- IDLE, no REQ: hold; outputs unchanged except GNTx/DONE cleared.
- IDLE, REQ sampled at edge e0: winner selected, MA/MB/MSGN/OWNER loaded from winner; GNT(winner) high for the cycle after e0; counter = SETTLE_CYCLES-1; go to WAIT.
- Arbitration: only one REQ -> that port. Both -> port != LAST (the last-completed owner). LAST resets to 1, so port 0 wins first.
- Zero fast path: if winner's A==0 or B==0, at e0 HI=LO=0, DONE=1, DONE_ID=winner, LAST=winner; state stays IDLE (GNT and DONE in same cycle).
- WAIT: counter != 0 -> decrement. Counter == 0 -> HI<=MHI, LO<=MLO, DONE<=1, DONE_ID<=OWNER, LAST<=OWNER, go IDLE.
- REQ inputs ignored in WAIT. Requester deasserts REQ no later than the cycle after GNT; REQ still high in a later IDLE cycle is a new request.
- MA/MB/MSGN change only at acceptance edges; stable for the entire WAIT.
- Width: HI:LO is the full 64-bit product from the multiplier; no truncation or saturation in this block.
- Reset (async, any state): state=IDLE, MA=MB=0, MSGN=0, HI=LO=0, DONE=0, DONE_ID=0, GNT0=GNT1=0, BUSY=0, LAST=1, counter=0. In-flight op is dropped with no DONE; requester reissues.

## Timing
- Acceptance edge e0 -> GNT during cycle e0..e1.
- Non-zero op: capture at edge e(SETTLE_CYCLES); DONE high cycle e(S)..e(S+1); earliest next acceptance at e(S+1).
- Throughput: one non-zero op per SETTLE_CYCLES+1 cycles; zero-operand ops one per cycle.
- SETTLE_CYCLES must be >= the multiplier's worst-case combinational delay in cycles.
- BUSY registered: high from e0 to e(S) for non-zero ops; never high for zero fast path.

## Test plan
- Single op, S=3: REQ0, SGN0=0, A0=0x0000_FFFF, B0=0x0001_0000 -> GNT0 one cycle after sample; DONE 3 edges after acceptance with HI=0x0000_0000, LO=0xFFFF_0000, DONE_ID=0.
- Signed op: REQ1, SGN1=1, A1=0xFFFF_FFFE (-2), B1=0x0000_0003 -> MSGN=1 through WAIT; HI=0xFFFF_FFFF, LO=0xFFFF_FFFA, DONE_ID=1.
- Contention: REQ0 and REQ1 held high continuously after reset -> grants alternate 0,1,0,1; each DONE_ID matches its GNT; MA/MB never change during BUSY.
- Zero fast path: REQ0 with A0=0x1234_5678, B0=0 -> GNT0 and DONE in the same cycle, HI=LO=0, BUSY stays 0; next REQ1 accepted the following edge.
- Reset mid-op: assert RST low one cycle after GNT0 -> all outputs to reset values immediately, no DONE; after release, REQ1 alone granted, port-0 priority restored on next contention.
- Parameter sweep S=1 and S=15: DONE exactly S edges after acceptance; captured product matches the reference model for random signed/unsigned operands, including 0x8000_0000 x 0x8000_0000 (signed HI=0x4000_0000, LO=0).

Source files
------------

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
// Two-port front end for the shared combinational 32x32 multiplier.
// Picks one requester (round-robin on contention), latches its operands
// onto the multiplier inputs, waits SETTLE_CYCLES for the ripple chain to
// resolve, then captures the 64-bit product and pulses DONE tagged with
// the owning port. Operands with a zero factor complete in the accept
// cycle without occupying the multiplier.
module mult_share_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic        sgn0_i,
    input  logic        sgn1_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] b0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] b1_i,
    input  logic [31:0] mhi_i,
    input  logic [31:0] mlo_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic [31:0] ma_o,
    output logic [31:0] mb_o,
    output logic        msgn_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o,
    output logic        done_id_o,
    output logic        busy_o
);

    // Counter starts at S-1 so the capture lands exactly S edges after accept.
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        last_q;
    logic        owner_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic [31:0] ma_q;
    logic [31:0] mb_q;
    logic        msgn_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;
    logic        done_id_q;
    logic        busy_q;

    logic        any_req_d;
    logic        winner_d;
    logic [31:0] a_d;
    logic [31:0] b_d;
    logic        sgn_d;
    logic        zero_op_d;

    // Arbitration: a lone requester wins; on contention the port that did
    // not complete last wins. The winner's operands are muxed for loading.
    always_comb begin
        any_req_d = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_d = ~last_q;
        end else begin
            winner_d = req1_i;
        end
        a_d       = winner_d ? a1_i : a0_i;
        b_d       = winner_d ? b1_i : b0_i;
        sgn_d     = winner_d ? sgn1_i : sgn0_i;
        zero_op_d = (a_d == 32'd0) || (b_d == 32'd0);
    end

    // Sequencer: accept in IDLE, count down the settle window in WAIT, capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ma_q      <= 32'd0;
            mb_q      <= 32'd0;
            msgn_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req_d) begin
                        ma_q    <= a_d;
                        mb_q    <= b_d;
                        msgn_q  <= sgn_d;
                        owner_q <= winner_d;
                        gnt0_q  <= ~winner_d;
                        gnt1_q  <= winner_d;
                        if (zero_op_d) begin
                            hi_q      <= 32'd0;
                            lo_q      <= 32'd0;
                            done_q    <= 1'b1;
                            done_id_q <= winner_d;
                            last_q    <= winner_d;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            busy_q  <= 1'b1;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        hi_q      <= mhi_i;
                        lo_q      <= mlo_i;
                        done_q    <= 1'b1;
                        done_id_q <= owner_q;
                        last_q    <= owner_q;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt0_o    = gnt0_q;
    assign gnt1_o    = gnt1_q;
    assign ma_o      = ma_q;
    assign mb_o      = mb_q;
    assign msgn_o    = msgn_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl
// Three controller instances (settle 3, 1, 15) share the requester inputs,
// each driving its own behavioural multiplier. Instance 0 is exercised by
// all scenarios; the other two join in for the settle-window sweep.
module tb_mult_share_ctrl;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0;
    logic        req1;
    logic        sgn0;
    logic        sgn1;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;

    logic [NI-1:0] gnt0V;
    logic [NI-1:0] gnt1V;
    logic [NI-1:0] msgnV;
    logic [NI-1:0] doneV;
    logic [NI-1:0] doneIdV;
    logic [NI-1:0] busyV;
    logic [31:0]   maV  [NI];
    logic [31:0]   mbV  [NI];
    logic [31:0]   mhiV [NI];
    logic [31:0]   mloV [NI];
    logic [31:0]   hiV  [NI];
    logic [31:0]   loV  [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : gInst
            localparam int unsigned SG = (g == 0) ? 3 : ((g == 1) ? 1 : 15);
            logic [63:0] prod;

            // Behavioural stand-in for the external combinational multiplier.
            always_comb begin
                if (msgnV[g]) begin
                    prod = $signed({{32{maV[g][31]}}, maV[g]}) * $signed({{32{mbV[g][31]}}, mbV[g]});
                end else begin
                    prod = {32'd0, maV[g]} * {32'd0, mbV[g]};
                end
            end
            assign mhiV[g] = prod[63:32];
            assign mloV[g] = prod[31:0];

            mult_share_ctrl #(.SETTLE_CYCLES(SG)) dut (
                .clk_i     (clk),
                .rst_ni    (rst_n),
                .req0_i    (req0),
                .req1_i    (req1),
                .sgn0_i    (sgn0),
                .sgn1_i    (sgn1),
                .a0_i      (a0),
                .b0_i      (b0),
                .a1_i      (a1),
                .b1_i      (b1),
                .mhi_i     (mhiV[g]),
                .mlo_i     (mloV[g]),
                .gnt0_o    (gnt0V[g]),
                .gnt1_o    (gnt1V[g]),
                .ma_o      (maV[g]),
                .mb_o      (mbV[g]),
                .msgn_o    (msgnV[g]),
                .hi_o      (hiV[g]),
                .lo_o      (loV[g]),
                .done_o    (doneV[g]),
                .done_id_o (doneIdV[g]),
                .busy_o    (busyV[g])
            );
        end
    endgenerate

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        id;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    int            passCount  = 0;
    int            checkCount = 0;
    int            cyc        = 0;
    int            accCyc     = 0;
    int            doneCyc [NI];
    logic [NI-1:0] doneFlag   = '0;
    logic [NI-1:0] mask       = 3'b001;
    logic          prevBusy   = 1'b0;
    logic [31:0]   prevMa     = 32'd0;
    logic [31:0]   prevMb     = 32'd0;
    logic          prevMsgn   = 1'b0;

    // Single comparison point: counts, and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference product computed with native 64-bit arithmetic.
    function automatic logic [63:0] refProduct(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sbv;
        longint unsigned ua;
        longint unsigned ub;
        if (sgn) begin
            sa  = longint'(signed'(a));
            sbv = longint'(signed'(b));
            return 64'(sa * sbv);
        end else begin
            ua = 64'(a);
            ub = 64'(b);
            return ua * ub;
        end
    endfunction

    function automatic int settleOf(input int k);
        case (k)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    task automatic pushExpected(input logic sgn, input logic [31:0] a, input logic [31:0] b, input logic id);
        logic [63:0] p;
        exp_t        e;
        p    = refProduct(sgn, a, b);
        e.hi = p[63:32];
        e.lo = p[31:0];
        e.id = id;
        if (mask[0]) sb0.push_back(e);
        if (mask[1]) sb1.push_back(e);
        if (mask[2]) sb2.push_back(e);
    endtask

    task automatic scoreDone(input int k);
        exp_t e;
        int   n;
        case (k)
            0:       n = sb0.size();
            1:       n = sb1.size();
            default: n = sb2.size();
        endcase
        checkOutput($sformatf("sb_pending_i%0d", k), 64'(n > 0), 64'd1);
        if (n > 0) begin
            case (k)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
            endcase
            checkOutput($sformatf("hi_i%0d", k), 64'(hiV[k]), 64'(e.hi));
            checkOutput($sformatf("lo_i%0d", k), 64'(loV[k]), 64'(e.lo));
            checkOutput($sformatf("done_id_i%0d", k), 64'(doneIdV[k]), 64'(e.id));
        end
    endtask

    // One clock: sample at the falling edge, score DONEs, watch operand stability.
    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (mask[k] && doneV[k]) begin
                doneFlag[k] = 1'b1;
                doneCyc[k]  = cyc;
                scoreDone(k);
            end
        end
        if (prevBusy && busyV[0]) begin
            checkOutput("ma_stable", 64'(maV[0]), 64'(prevMa));
            checkOutput("mb_stable", 64'(mbV[0]), 64'(prevMb));
            checkOutput("msgn_stable", 64'(msgnV[0]), 64'(prevMsgn));
        end
        prevBusy = busyV[0];
        prevMa   = maV[0];
        prevMb   = mbV[0];
        prevMsgn = msgnV[0];
    endtask

    task automatic armDone();
        doneFlag = '0;
        for (int k = 0; k < NI; k++) doneCyc[k] = -1;
    endtask

    task automatic applyStimulus(input int port, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (port == 0) begin
            req0 = 1'b1;
            sgn0 = sgn;
            a0   = a;
            b0   = b;
        end else begin
            req1 = 1'b1;
            sgn1 = sgn;
            a1   = a;
            b1   = b;
        end
    endtask

    task automatic checkGrant(input int port);
        checkOutput("gnt0", 64'(gnt0V[0]), 64'(port == 0));
        checkOutput("gnt1", 64'(gnt1V[0]), 64'(port == 1));
        accCyc = cyc;
    endtask

    task automatic waitDone(input logic [NI-1:0] m, input int budget, input logic zeroPath);
        int n;
        n = 0;
        while (((doneFlag & m) != m) && (n < budget)) begin
            stepCycle();
            n++;
        end
        for (int k = 0; k < NI; k++) begin
            if (m[k]) begin
                checkOutput($sformatf("done_seen_i%0d", k), 64'(doneFlag[k]), 64'd1);
                checkOutput($sformatf("latency_i%0d", k), 64'(doneCyc[k] - accCyc),
                            64'(zeroPath ? 0 : settleOf(k)));
            end
        end
    endtask

    task automatic doReset(input logic check);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb0.delete();
        sb1.delete();
        sb2.delete();
        if (check) begin
            checkOutput("rst_gnt0", 64'(gnt0V[0]), 64'd0);
            checkOutput("rst_gnt1", 64'(gnt1V[0]), 64'd0);
            checkOutput("rst_ma", 64'(maV[0]), 64'd0);
            checkOutput("rst_mb", 64'(mbV[0]), 64'd0);
            checkOutput("rst_msgn", 64'(msgnV[0]), 64'd0);
            checkOutput("rst_hi", 64'(hiV[0]), 64'd0);
            checkOutput("rst_lo", 64'(loV[0]), 64'd0);
            checkOutput("rst_done", 64'(doneV[0]), 64'd0);
            checkOutput("rst_done_id", 64'(doneIdV[0]), 64'd0);
            checkOutput("rst_busy", 64'(busyV[0]), 64'd0);
        end
        stepCycle();
        stepCycle();
        rst_n = 1'b1;
    endtask

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence.
    initial begin
        logic        modelLast;
        logic        w;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        sgn0  = 1'b0;
        sgn1  = 1'b0;
        a0    = 32'd0;
        b0    = 32'd0;
        a1    = 32'd0;
        b1    = 32'd0;
        armDone();

        $display("[TB] reset state");
        doReset(1'b1);

        $display("[TB] single unsigned op on port 0");
        applyStimulus(0, 1'b0, 32'h0000_FFFF, 32'h0001_0000);
        pushExpected(1'b0, 32'h0000_FFFF, 32'h0001_0000, 1'b0);
        armDone();
        stepCycle();
        checkGrant(0);
        checkOutput("t1_busy", 64'(busyV[0]), 64'd1);
        checkOutput("t1_ma", 64'(maV[0]), 64'h0000_FFFF);
        checkOutput("t1_mb", 64'(mbV[0]), 64'h0001_0000);
        checkOutput("t1_msgn", 64'(msgnV[0]), 64'd0);
        req0 = 1'b0;
        waitDone(3'b001, 10, 1'b0);
        checkOutput("t1_busy_after", 64'(busyV[0]), 64'd0);

        $display("[TB] signed op on port 1");
        applyStimulus(1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0003);
        pushExpected(1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        armDone();
        stepCycle();
        checkGrant(1);
        req1 = 1'b0;
        checkOutput("t2_msgn_accept", 64'(msgnV[0]), 64'd1);
        stepCycle();
        checkOutput("t2_msgn_wait", 64'(msgnV[0]), 64'd1);
        waitDone(3'b001, 10, 1'b0);

        $display("[TB] continuous contention");
        doReset(1'b0);
        modelLast = 1'b1;
        applyStimulus(0, 1'b0, 32'd3, 32'd5);
        applyStimulus(1, 1'b1, 32'hFFFF_FFF9, 32'd6);
        for (int i = 0; i < 4; i++) begin
            w = ~modelLast;
            pushExpected(w ? sgn1 : sgn0, w ? a1 : a0, w ? b1 : b0, w);
            armDone();
            stepCycle();
            checkGrant(int'(w));
            waitDone(3'b001, 10, 1'b0);
            modelLast = w;
        end
        req0 = 1'b0;
        req1 = 1'b0;

        $display("[TB] zero-operand fast path");
        applyStimulus(0, 1'b0, 32'h1234_5678, 32'd0);
        pushExpected(1'b0, 32'h1234_5678, 32'd0, 1'b0);
        armDone();
        stepCycle();
        checkGrant(0);
        checkOutput("t4_busy", 64'(busyV[0]), 64'd0);
        waitDone(3'b001, 0, 1'b1);
        req0 = 1'b0;
        applyStimulus(1, 1'b0, 32'h10, 32'h20);
        pushExpected(1'b0, 32'h10, 32'h20, 1'b1);
        armDone();
        stepCycle();
        checkGrant(1);
        req1 = 1'b0;
        waitDone(3'b001, 10, 1'b0);

        $display("[TB] reset in the middle of an op");
        applyStimulus(0, 1'b0, 32'd7, 32'd9);
        pushExpected(1'b0, 32'd7, 32'd9, 1'b0);
        armDone();
        stepCycle();
        checkGrant(0);
        checkOutput("t5_busy_pre", 64'(busyV[0]), 64'd1);
        req0 = 1'b0;
        doReset(1'b1);
        checkOutput("t5_no_done", 64'(doneFlag[0]), 64'd0);
        applyStimulus(1, 1'b0, 32'd2, 32'd3);
        pushExpected(1'b0, 32'd2, 32'd3, 1'b1);
        armDone();
        stepCycle();
        checkGrant(1);
        req1 = 1'b0;
        waitDone(3'b001, 10, 1'b0);
        applyStimulus(0, 1'b0, 32'd11, 32'd13);
        applyStimulus(1, 1'b0, 32'd17, 32'd19);
        pushExpected(1'b0, 32'd11, 32'd13, 1'b0);
        armDone();
        stepCycle();
        checkGrant(0);
        req0 = 1'b0;
        req1 = 1'b0;
        waitDone(3'b001, 10, 1'b0);

        $display("[TB] settle-window sweep");
        doReset(1'b0);
        mask = 3'b111;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                rs = (i == 0);
                ra = 32'h8000_0000;
                rb = 32'h8000_0000;
            end else begin
                rs = 1'($urandom_range(0, 1));
                ra = $urandom;
                rb = $urandom;
                if (ra == 32'd0) ra = 32'd1;
                if (rb == 32'd0) rb = 32'd1;
            end
            applyStimulus(0, rs, ra, rb);
            pushExpected(rs, ra, rb, 1'b0);
            armDone();
            stepCycle();
            accCyc = cyc;
            checkOutput("sw_gnt0", 64'(gnt0V), 64'(3'b111));
            checkOutput("sw_gnt1", 64'(gnt1V), 64'd0);
            checkOutput("sw_busy", 64'(busyV), 64'(3'b111));
            req0 = 1'b0;
            waitDone(3'b111, 20, 1'b0);
        end
        mask = 3'b001;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
